// File: rtl/framebuffer_arbiter_if.sv
// Host drawing port of the framebuffer arbiter: request/busy handshake plus
// the completion pulse and read data that come back from the shared RAM.
interface framebuffer_arbiter_if #(
    parameter int ADDR_W = 15
) ();
    logic              HOST_REQ;
    logic              HOST_WE;
    logic [ADDR_W-1:0] HOST_ADDR;
    logic [7:0]        HOST_WDATA;
    logic              HOST_BUSY;
    logic              HOST_DONE;
    logic [7:0]        HOST_RDATA;

    modport master (
        output HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
        input  HOST_BUSY, HOST_DONE, HOST_RDATA
    );

    modport slave (
        input  HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
        output HOST_BUSY, HOST_DONE, HOST_RDATA
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Shares one single-port framebuffer RAM between 4x4-replicated VGA scanout
// (fixed slots) and a one-entry buffered host port that fills every other cycle.
module framebuffer_arbiter #(
    parameter int H_PIX  = 160,
    parameter int V_PIX  = 120,
    parameter int ADDR_W = 15
) (
    input  logic                  CLK_25MHz,
    input  logic                  RESET,
    input  logic [9:0]            CURX,
    input  logic [8:0]            CURY,
    input  logic                  HBLANK,
    input  logic                  VBLANK,
    output logic [7:0]            COLOR_DATA_OUT,
    framebuffer_arbiter_if.slave  host,
    output logic [ADDR_W-1:0]     RAM_ADDR,
    output logic                  RAM_WE,
    output logic [7:0]            RAM_WDATA,
    input  logic [7:0]            RAM_RDATA
);

    localparam logic [ADDR_W-1:0] FB_SIZE    = ADDR_W'(H_PIX * V_PIX);
    localparam logic [7:0]        LAST_GROUP = 8'(H_PIX - 1);
    localparam logic [7:0]        ROW_LIMIT  = 8'(V_PIX);

    logic              active;
    logic              video_slot;
    logic              fetch_phase;
    logic              show_phase;
    logic [7:0]        group_next;
    logic [7:0]        row_sel;
    logic [7:0]        row_wrap;
    logic [ADDR_W-1:0] video_addr;

    logic              prev_video;
    logic [7:0]        next_pix;

    logic              pend_valid;
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_wdata;
    logic              pend_in_range;
    logic              issue;

    logic              tag1_valid;
    logic              tag1_read;
    logic              tag1_oor;
    logic              done_q;
    logic [7:0]        rdata_q;

    assign active      = !HBLANK && !VBLANK;
    assign video_slot  = active && (CURX[1:0] == 2'd1);
    assign fetch_phase = active && (CURX[1:0] == 2'd2);
    assign show_phase  = active && (CURX[1:0] == 2'd3);

    // Each slot prefetches the next group; the last group of a line fetches
    // group 0 of the line after, where (CURY+1)>>2 wraps back to row 0.
    always_comb begin
        group_next = CURX[9:2] + 8'd1;
        row_sel    = {1'b0, CURY[8:2]};
        row_wrap   = {1'b0, CURY[8:2]} + {7'd0, &CURY[1:0]};
        if (CURX[9:2] == LAST_GROUP) begin
            group_next = '0;
            row_sel    = (row_wrap >= ROW_LIMIT) ? 8'd0 : row_wrap;
        end
        video_addr = (ADDR_W'(row_sel) << 7) + (ADDR_W'(row_sel) << 5)
                   + ADDR_W'(group_next);
    end

    always_ff @(posedge CLK_25MHz or posedge RESET) begin
        if (RESET) begin
            prev_video     <= 1'b0;
            next_pix       <= '0;
            COLOR_DATA_OUT <= '0;
        end else begin
            prev_video <= video_slot;
            if (fetch_phase && prev_video) begin
                next_pix <= RAM_RDATA;
            end
            if (show_phase) begin
                COLOR_DATA_OUT <= next_pix;
            end
        end
    end

    // The host only ever gets a cycle the video side does not claim.
    assign issue         = pend_valid && !video_slot;
    assign pend_in_range = (pend_addr < FB_SIZE);

    always_ff @(posedge CLK_25MHz or posedge RESET) begin
        if (RESET) begin
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else if (issue) begin
            pend_valid <= 1'b0;
        end else if (host.HOST_REQ && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_we    <= host.HOST_WE;
            pend_addr  <= host.HOST_ADDR;
            pend_wdata <= host.HOST_WDATA;
        end
    end

    always_ff @(posedge CLK_25MHz or posedge RESET) begin
        if (RESET) begin
            tag1_valid <= 1'b0;
            tag1_read  <= 1'b0;
            tag1_oor   <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            tag1_valid <= issue;
            tag1_read  <= !pend_we;
            tag1_oor   <= !pend_in_range;
            done_q     <= tag1_valid;
            if (tag1_valid && tag1_read) begin
                rdata_q <= tag1_oor ? 8'h00 : RAM_RDATA;
            end
        end
    end

    always_comb begin
        RAM_ADDR = '0;
        if (video_slot) begin
            RAM_ADDR = video_addr;
        end else if (pend_valid) begin
            RAM_ADDR = pend_addr;
        end
        RAM_WE    = issue && pend_we && pend_in_range;
        RAM_WDATA = pend_wdata;
    end

    assign host.HOST_BUSY  = pend_valid;
    assign host.HOST_DONE  = done_q;
    assign host.HOST_RDATA = rdata_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter: host completions and RAM writes are
// predicted into queues and retired by a negedge monitor; scanout is checked inline.
module tb_framebuffer_arbiter;

    localparam int ADDR_W = 15;

    logic              CLK_25MHz = 1'b0;
    logic              RESET;
    logic [9:0]        CURX;
    logic [8:0]        CURY;
    logic              HBLANK;
    logic              VBLANK;
    logic [7:0]        COLOR_DATA_OUT;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic              RAM_WE;
    logic [7:0]        RAM_WDATA;
    logic [7:0]        RAM_RDATA;

    framebuffer_arbiter_if #(.ADDR_W(ADDR_W)) host ();

    framebuffer_arbiter #(.H_PIX(160), .V_PIX(120), .ADDR_W(ADDR_W)) dut (
        .CLK_25MHz      (CLK_25MHz),
        .RESET          (RESET),
        .CURX           (CURX),
        .CURY           (CURY),
        .HBLANK         (HBLANK),
        .VBLANK         (VBLANK),
        .COLOR_DATA_OUT (COLOR_DATA_OUT),
        .host           (host),
        .RAM_ADDR       (RAM_ADDR),
        .RAM_WE         (RAM_WE),
        .RAM_WDATA      (RAM_WDATA),
        .RAM_RDATA      (RAM_RDATA)
    );

    always #20 CLK_25MHz = ~CLK_25MHz;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always @(posedge CLK_25MHz) cycle <= cycle + 1;

    // Synchronous single-port RAM model with a bench-side preload port.
    logic [7:0]        mem [0:32767];
    logic              preloadEn = 1'b0;
    logic [ADDR_W-1:0] preloadAddr = '0;
    logic [7:0]        preloadData = '0;

    always @(posedge CLK_25MHz) begin
        if (preloadEn) mem[preloadAddr] <= preloadData;
        else if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
        RAM_RDATA <= mem[RAM_ADDR];
    end

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } ramExp_t;

    typedef struct {
        int         cyc;
        bit         isRead;
        logic [7:0] rdata;
    } doneExp_t;

    ramExp_t  ramQ[$];
    doneExp_t doneQ[$];
    ramExp_t  re;
    doneExp_t de;

    // Monitor: every RAM write and every HOST_DONE must match the next prediction.
    always @(negedge CLK_25MHz) begin
        if (!RESET) begin
            if (RAM_WE) begin
                checks++;
                if (ramQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL ram_write_unexpected actual addr=0x%0h data=0x%0h cyc=%0d required=no write",
                             RAM_ADDR, RAM_WDATA, cycle);
                end else begin
                    re = ramQ.pop_front();
                    if (RAM_ADDR !== re.addr || RAM_WDATA !== re.data || cycle != re.cyc) begin
                        failures++;
                        $display("[TB] FAIL ram_write actual addr=0x%0h data=0x%0h cyc=%0d required addr=0x%0h data=0x%0h cyc=%0d",
                                 RAM_ADDR, RAM_WDATA, cycle, re.addr, re.data, re.cyc);
                    end
                end
            end
            if (host.HOST_DONE) begin
                checks++;
                if (doneQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL host_done_unexpected actual done=1 cyc=%0d required=no done", cycle);
                end else begin
                    de = doneQ.pop_front();
                    if (cycle != de.cyc || (de.isRead && host.HOST_RDATA !== de.rdata)) begin
                        failures++;
                        $display("[TB] FAIL host_done actual rdata=0x%0h cyc=%0d required rdata=0x%0h cyc=%0d (read=%0d)",
                                 host.HOST_RDATA, cycle, de.rdata, de.cyc, de.isRead);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, actual, expected, cycle);
        end
    endtask

    task automatic tick();
        @(posedge CLK_25MHz);
        #1;
        host.HOST_REQ = 1'b0;
    endtask

    task automatic setPos(input int x, input int y, input bit hb, input bit vb);
        CURX   = 10'(x);
        CURY   = 9'(y);
        HBLANK = hb;
        VBLANK = vb;
    endtask

    task automatic preload(input int addr, input logic [7:0] data);
        preloadAddr = ADDR_W'(addr);
        preloadData = data;
        preloadEn   = 1'b1;
        tick();
        preloadEn   = 1'b0;
    endtask

    task automatic driveReq(input bit we, input int addr, input logic [7:0] wdata);
        host.HOST_WE    = we;
        host.HOST_ADDR  = ADDR_W'(addr);
        host.HOST_WDATA = wdata;
        host.HOST_REQ   = 1'b1;
    endtask

    // Issue one host access; issueDelay is the hand-derived cycle count from
    // the sampling edge to the RAM issue cycle (1, or 2 behind a video slot).
    task automatic applyStimulus(input bit we, input int addr, input logic [7:0] wdata,
                                 input int issueDelay, input bit expWrite, input logic [7:0] expRdata);
        driveReq(we, addr, wdata);
        if (we && expWrite) ramQ.push_back('{cycle + issueDelay, ADDR_W'(addr), wdata});
        doneQ.push_back('{cycle + issueDelay + 2, !we, expRdata});
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40; i++) begin
            if (ramQ.size() == 0 && doneQ.size() == 0) break;
            tick();
        end
        checks++;
        if (ramQ.size() != 0 || doneQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout actual pending ram=%0d done=%0d required=0 0",
                     ramQ.size(), doneQ.size());
            ramQ.delete();
            doneQ.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int vx[4]   = '{1, 5, 637, 637};
    int vy[4]   = '{0, 4, 3, 479};
    int vexp[4] = '{1, 162, 160, 0};

    initial begin
        RESET           = 1'b1;
        host.HOST_REQ   = 1'b0;
        host.HOST_WE    = 1'b0;
        host.HOST_ADDR  = '0;
        host.HOST_WDATA = '0;
        setPos(0, 0, 1'b1, 1'b1);

        $display("[TB] reset values");
        repeat (2) @(posedge CLK_25MHz);
        @(negedge CLK_25MHz);
        checkOutput("rst_color", 32'(COLOR_DATA_OUT), 32'h0);
        checkOutput("rst_busy", 32'(host.HOST_BUSY), 32'h0);
        checkOutput("rst_done", 32'(host.HOST_DONE), 32'h0);
        checkOutput("rst_rdata", 32'(host.HOST_RDATA), 32'h0);
        checkOutput("rst_ram_we", 32'(RAM_WE), 32'h0);
        tick();
        RESET = 1'b0;

        $display("[TB] reset discards a pending write");
        tick();
        driveReq(1'b1, 32'h50, 8'h77);
        @(posedge CLK_25MHz);
        #1;
        RESET         = 1'b1;
        host.HOST_REQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_25MHz);
            checkOutput("rstmid_ram_we", 32'(RAM_WE), 32'h0);
            checkOutput("rstmid_busy", 32'(host.HOST_BUSY), 32'h0);
            checkOutput("rstmid_color", 32'(COLOR_DATA_OUT), 32'h0);
        end
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_25MHz);
            checkOutput("rstmid_no_done", 32'(host.HOST_DONE), 32'h0);
            checkOutput("rstmid_no_we", 32'(RAM_WE), 32'h0);
            tick();
        end

        $display("[TB] scanout addresses");
        for (int i = 0; i < 4; i++) begin
            tick();
            setPos(vx[i], vy[i], 1'b0, 1'b0);
            @(negedge CLK_25MHz);
            checkOutput("scan_addr", 32'(RAM_ADDR), 32'(vexp[i]));
        end

        $display("[TB] pixel path");
        tick();
        setPos(700, 2, 1'b1, 1'b0);
        preload(160, 8'hA5);
        preload(161, 8'h3C);
        for (int x = 600; x < 800; x++) begin
            tick();
            setPos(x, 3, x >= 640, 1'b0);
            @(negedge CLK_25MHz);
            if (x >= 640) checkOutput("color_blank", 32'(COLOR_DATA_OUT), 32'hA5);
        end
        for (int x = 0; x < 8; x++) begin
            tick();
            setPos(x, 4, 1'b0, 1'b0);
            @(negedge CLK_25MHz);
            checkOutput("color_line", 32'(COLOR_DATA_OUT), (x < 4) ? 32'hA5 : 32'h3C);
        end

        $display("[TB] host write in hblank");
        tick();
        setPos(700, 4, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h123, 8'h5C, 1, 1'b1, 8'h00);
        tick();
        @(negedge CLK_25MHz);
        checkOutput("wr_busy_issue", 32'(host.HOST_BUSY), 32'h1);
        checkOutput("wr_addr_issue", 32'(RAM_ADDR), 32'h123);
        tick();
        @(negedge CLK_25MHz);
        checkOutput("wr_busy_after", 32'(host.HOST_BUSY), 32'h0);
        waitDrain();

        $display("[TB] collision with video slot");
        tick();
        setPos(4, 4, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h200, 8'h11, 2, 1'b1, 8'h00);
        tick();
        setPos(5, 4, 1'b0, 1'b0);
        @(negedge CLK_25MHz);
        checkOutput("col_video_addr", 32'(RAM_ADDR), 32'd162);
        checkOutput("col_we_blocked", 32'(RAM_WE), 32'h0);
        checkOutput("col_busy", 32'(host.HOST_BUSY), 32'h1);
        tick();
        setPos(6, 4, 1'b0, 1'b0);
        @(negedge CLK_25MHz);
        checkOutput("col_issue_addr", 32'(RAM_ADDR), 32'h200);
        tick();
        setPos(7, 4, 1'b0, 1'b0);
        tick();
        setPos(8, 4, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] host reads and range check");
        tick();
        setPos(700, 4, 1'b1, 1'b0);
        preload(19199, 8'h3C);
        preload(19200, 8'hEE);
        tick();
        applyStimulus(1'b0, 19200, 8'h00, 1, 1'b0, 8'h00);
        waitDrain();
        applyStimulus(1'b0, 19199, 8'h00, 1, 1'b0, 8'h3C);
        waitDrain();
        applyStimulus(1'b1, 19200, 8'hAB, 1, 1'b0, 8'h00);
        waitDrain();
        @(negedge CLK_25MHz);
        checkOutput("rdata_hold", 32'(host.HOST_RDATA), 32'h3C);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
